// File: rtl/pid_seq.sv
// pid_seq: sequences pitch saturation, integration and derivative once per inertial sample.
// Latency: vld at edge N -> pid_vld high after edge N+4; one sample per 5 clocks at most.
// No backpressure: vld while busy is dropped (counted on drop_cnt when DROP_CNT_EN is defined).
module pid_seq #(
  parameter int D_QUEUE_DEPTH = 2,
  parameter int INTEG_W       = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [15:0] ptch,
  input  logic        pwr_up,
  input  logic        rider_off,
  output logic [9:0]  ptch_err_sat,
  output logic [9:0]  ptch_err_I,
  output logic [6:0]  ptch_D_diff_sat,
  output logic        pid_vld,
`ifdef DROP_CNT_EN
  output logic [7:0]  drop_cnt,
`endif
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, SAT, INTEG, DIFF, DONE} state_t;

  state_t state_q, state_d;

  logic               cap_en, sat_en, integ_en, diff_en, pid_vld_d;
  logic signed [15:0] ptch_cap;
  logic signed [9:0]  sat_val;
  logic [INTEG_W-1:0] acc, addend, sum;
  logic               ovf, acc_clr;
  logic signed [9:0]  d_q [D_QUEUE_DEPTH];
  logic signed [10:0] diff;
  logic [6:0]         diff_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cap_en    = 1'b0;
    sat_en    = 1'b0;
    integ_en  = 1'b0;
    diff_en   = 1'b0;
    pid_vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (vld) begin
          cap_en  = 1'b1;
          state_d = SAT;
        end
      end
      SAT: begin
        sat_en  = 1'b1;
        state_d = INTEG;
      end
      INTEG: begin
        integ_en = 1'b1;
        state_d  = DIFF;
      end
      DIFF: begin
        diff_en = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        pid_vld_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptch_cap <= '0;
    else if (cap_en) ptch_cap <= ptch;
  end

  always_comb begin
    if (ptch_cap > 16'sd511)       sat_val = 10'sd511;
    else if (ptch_cap < -16'sd512) sat_val = -10'sd512;
    else                           sat_val = ptch_cap[9:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptch_err_sat <= '0;
    else if (sat_en) ptch_err_sat <= sat_val;
  end

  // Signed overflow: same-sign operands producing an opposite-sign sum; hold instead of wrapping.
  assign addend  = {{(INTEG_W-10){ptch_err_sat[9]}}, ptch_err_sat};
  assign sum     = acc + addend;
  assign ovf     = (acc[INTEG_W-1] == addend[INTEG_W-1]) && (sum[INTEG_W-1] != acc[INTEG_W-1]);
  assign acc_clr = rider_off | ~pwr_up;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                acc <= '0;
    else if (acc_clr)          acc <= '0;
    else if (integ_en && !ovf) acc <= sum;
  end

  assign ptch_err_I = acc[INTEG_W-1 -: 10];

  assign diff = {ptch_err_sat[9], ptch_err_sat} - {d_q[D_QUEUE_DEPTH-1][9], d_q[D_QUEUE_DEPTH-1]};

  always_comb begin
    if (diff > 11'sd63)       diff_sat = 7'h3F;
    else if (diff < -11'sd64) diff_sat = 7'h40;
    else                      diff_sat = diff[6:0];
  end

  // History survives integrator clears; only reset empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D_QUEUE_DEPTH; i++) d_q[i] <= '0;
      ptch_D_diff_sat <= '0;
    end else if (diff_en) begin
      d_q[0] <= ptch_err_sat;
      for (int i = 1; i < D_QUEUE_DEPTH; i++) d_q[i] <= d_q[i-1];
      ptch_D_diff_sat <= diff_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pid_vld <= 1'b0;
    else        pid_vld <= pid_vld_d;
  end

`ifdef DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 drop_cnt <= '0;
    else if (rider_off)                         drop_cnt <= '0;
    else if (vld && busy && drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_pid_seq.sv
// Directed bench for pid_seq: vector table plus hand sequences for overflow, clear, drop and reset.
`timescale 1ns/1ps
module tb_pid_seq;

  logic        clk = 1'b0;
  logic        rst_n, vld, pwr_up, rider_off;
  logic [15:0] ptch;
  logic [9:0]  ptch_err_sat, ptch_err_I;
  logic [6:0]  ptch_D_diff_sat;
  logic        pid_vld, busy;
`ifdef DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] ptch;
    logic        pwr_up;
    logic        rider_off;
    logic [9:0]  e_sat;
    logic [9:0]  e_i;
    logic [6:0]  e_d;
  } vec_t;

  always #5 clk = ~clk;

  pid_seq dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .vld             (vld),
    .ptch            (ptch),
    .pwr_up          (pwr_up),
    .rider_off       (rider_off),
    .ptch_err_sat    (ptch_err_sat),
    .ptch_err_I      (ptch_err_I),
    .ptch_D_diff_sat (ptch_D_diff_sat),
    .pid_vld         (pid_vld),
`ifdef DROP_CNT_EN
    .drop_cnt        (drop_cnt),
`endif
    .busy            (busy)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Called at posedge+1; returns the number of edges from the vld edge to pid_vld (-1 if none).
  task automatic send(input logic [15:0] p, output int lat);
    vld  = 1'b1;
    ptch = p;
    @(posedge clk); #1;
    vld  = 1'b0;
    lat  = -1;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (pid_vld) lat = k;
    end
  endtask

  initial begin
    vec_t       tbl [18];
    int         lat;
    int         cnt;
    int         first;
    logic [9:0] sat_seen;

    rst_n = 1'b0; vld = 1'b0; ptch = '0; pwr_up = 1'b1; rider_off = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst sat",  {22'd0, ptch_err_sat}, 32'h0);
    chk("rst I",    {22'd0, ptch_err_I}, 32'h0);
    chk("rst D",    {25'd0, ptch_D_diff_sat}, 32'h0);
    chk("rst pvld", {31'd0, pid_vld}, 32'h0);
    chk("rst busy", {31'd0, busy}, 32'h0);
`ifdef DROP_CNT_EN
    chk("rst drop", {24'd0, drop_cnt}, 32'h0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    //            ptch      pwr   roff  sat      I        D
    tbl[0]  = '{16'h0400, 1'b1, 1'b0, 10'h1FF, 10'h001, 7'h3F};
    tbl[1]  = '{16'hF830, 1'b1, 1'b0, 10'h200, 10'h3FF, 7'h40};
    tbl[2]  = '{16'hFFFB, 1'b1, 1'b0, 10'h3FB, 10'h3FF, 7'h40};
    tbl[3]  = '{16'h0000, 1'b1, 1'b1, 10'h000, 10'h000, 7'h3F};
    tbl[4]  = '{16'h0100, 1'b1, 1'b0, 10'h100, 10'h001, 7'h3F};
    tbl[5]  = '{16'h0100, 1'b1, 1'b0, 10'h100, 10'h002, 7'h3F};
    tbl[6]  = '{16'h0100, 1'b1, 1'b0, 10'h100, 10'h003, 7'h00};
    tbl[7]  = '{16'h0100, 1'b1, 1'b0, 10'h100, 10'h004, 7'h00};
    tbl[8]  = '{16'h0014, 1'b1, 1'b0, 10'h014, 10'h004, 7'h40};
    tbl[9]  = '{16'h001E, 1'b1, 1'b0, 10'h01E, 10'h004, 7'h40};
    tbl[10] = '{16'h0032, 1'b1, 1'b0, 10'h032, 10'h004, 7'h1E};
    tbl[11] = '{16'h000A, 1'b1, 1'b0, 10'h00A, 10'h004, 7'h6C};
    tbl[12] = '{16'hFDA8, 1'b0, 1'b0, 10'h200, 10'h000, 7'h40};
    tbl[13] = '{16'h0000, 1'b1, 1'b0, 10'h000, 10'h000, 7'h76};
    tbl[14] = '{16'h0000, 1'b1, 1'b0, 10'h000, 10'h000, 7'h3F};
    tbl[15] = '{16'h0064, 1'b1, 1'b0, 10'h064, 10'h000, 7'h3F};
    tbl[16] = '{16'h0064, 1'b1, 1'b0, 10'h064, 10'h000, 7'h3F};
    tbl[17] = '{16'hFF9C, 1'b1, 1'b0, 10'h39C, 10'h000, 7'h40};

    for (int i = 0; i < 18; i++) begin
      pwr_up    = tbl[i].pwr_up;
      rider_off = tbl[i].rider_off;
      send(tbl[i].ptch, lat);
      chk($sformatf("v%0d latency", i), lat, 32'd4);
      chk($sformatf("v%0d sat", i), {22'd0, ptch_err_sat}, {22'd0, tbl[i].e_sat});
      chk($sformatf("v%0d I", i),   {22'd0, ptch_err_I},   {22'd0, tbl[i].e_i});
      chk($sformatf("v%0d D", i),   {25'd0, ptch_D_diff_sat}, {25'd0, tbl[i].e_d});
    end
    pwr_up = 1'b1; rider_off = 1'b0;

    // Overflow: 256 x 511 reaches 130816; the 257th add must hold, not wrap.
    rider_off = 1'b1;
    @(posedge clk); #1;
    rider_off = 1'b0;
    for (int i = 1; i <= 257; i++) begin
      send(16'd511, lat);
      if (i == 255) chk("ovf I@255", {22'd0, ptch_err_I}, 32'd509);
      if (i == 256) chk("ovf I@256", {22'd0, ptch_err_I}, 32'd511);
    end
    chk("ovf latency", lat, 32'd4);
    chk("ovf I@257",   {22'd0, ptch_err_I}, 32'd511);
    chk("ovf sat",     {22'd0, ptch_err_sat}, 32'h1FF);
    chk("ovf D",       {25'd0, ptch_D_diff_sat}, 32'h0);

    // Clear coinciding with INTEG wins; sequence still completes.
    ptch = 16'd100; vld = 1'b1;
    @(posedge clk); #1; vld = 1'b0;
    @(posedge clk); #1; rider_off = 1'b1;
    @(posedge clk); #1; rider_off = 1'b0;
    chk("clr I",    {22'd0, ptch_err_I}, 32'h0);
    chk("clr sat",  {22'd0, ptch_err_sat}, 32'h064);
    chk("clr busy", {31'd0, busy}, 32'h1);
    @(posedge clk); #1;
    chk("clr pvld early", {31'd0, pid_vld}, 32'h0);
    @(posedge clk); #1;
    chk("clr pvld", {31'd0, pid_vld}, 32'h1);
    chk("clr I2",   {22'd0, ptch_err_I}, 32'h0);
    chk("clr D",    {25'd0, ptch_D_diff_sat}, 32'h40);
    @(posedge clk); #1;
    chk("clr pvld width", {31'd0, pid_vld}, 32'h0);

    // Second vld two cycles after the first is dropped.
    ptch = 16'hFF00; vld = 1'b1;
    @(posedge clk); #1; vld = 1'b0;
    @(posedge clk); #1; vld = 1'b1; ptch = 16'd500;
    @(posedge clk); #1; vld = 1'b0;
    cnt = 0; first = -1; sat_seen = '0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (pid_vld) begin
        cnt++;
        if (first < 0) begin
          first    = k;
          sat_seen = ptch_err_sat;
        end
      end
    end
    chk("drop first pvld", first, 32'd2);
    chk("drop pvld count", cnt, 32'd1);
    chk("drop sat",        {22'd0, sat_seen}, 32'h300);
    chk("drop I",          {22'd0, ptch_err_I}, 32'h3FF);
`ifdef DROP_CNT_EN
    chk("drop cnt", {24'd0, drop_cnt}, 32'd1);
`endif

    // Async reset while in DIFF.
    ptch = 16'd300; vld = 1'b1;
    @(posedge clk); #1; vld = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre-rst busy", {31'd0, busy}, 32'h1);
    chk("pre-rst sat",  {22'd0, ptch_err_sat}, 32'h12C);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-rst sat",  {22'd0, ptch_err_sat}, 32'h0);
    chk("mid-rst I",    {22'd0, ptch_err_I}, 32'h0);
    chk("mid-rst D",    {25'd0, ptch_D_diff_sat}, 32'h0);
    chk("mid-rst pvld", {31'd0, pid_vld}, 32'h0);
    chk("mid-rst busy", {31'd0, busy}, 32'h0);
    @(posedge clk); #4 rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (pid_vld) cnt++;
    end
    chk("post-rst no pvld", cnt, 32'd0);
    send(16'hFFFB, lat);
    chk("post-rst latency", lat, 32'd4);
    chk("post-rst sat", {22'd0, ptch_err_sat}, 32'h3FB);
    chk("post-rst I",   {22'd0, ptch_err_I}, 32'h3FF);
    chk("post-rst D",   {25'd0, ptch_D_diff_sat}, 32'h7B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
